// File: rtl/jamma_joy_scanner_pkg.sv
// Shared constants and state encoding for the JAMMA joystick scanner.
package jamma_joy_scanner_pkg;

    localparam logic       JSEL_P1   = 1'b0;
    localparam logic       JSEL_P2   = 1'b1;
    localparam logic [7:0] JOY_IDLE  = 8'hFF;
    localparam logic [1:0] COIN_IDLE = 2'b11;

    typedef enum logic [1:0] {
        SETTLE_A = 2'd0,
        SAMPLE_A = 2'd1,
        SETTLE_B = 2'd2,
        SAMPLE_B = 2'd3
    } scan_state_e;

endpackage

// File: rtl/jamma_debounce_bit.sv
// Per-bit debounce filter: the clean output follows the raw sample only after
// DEBOUNCE_SCANS consecutive enabled samples that disagree with it.
module jamma_debounce_bit
    import jamma_joy_scanner_pkg::*;
#(
    parameter int   DEBOUNCE_SCANS = 3,
    parameter logic RESET_VAL      = 1'b1
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic sample_en_i,
    input  logic raw_i,
    output logic clean_o
);

    localparam logic [3:0] CNT_LAST = 4'(DEBOUNCE_SCANS - 1);

    logic [3:0] cnt_q, cnt_d;
    logic       clean_q, clean_d;

    // Next-state: agreement clears the run, the final disagreeing sample commits.
    always_comb begin
        cnt_d   = cnt_q;
        clean_d = clean_q;
        if (sample_en_i) begin
            if (raw_i == clean_q) begin
                cnt_d = '0;
            end else if (cnt_q >= CNT_LAST) begin
                clean_d = raw_i;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    // Counter and clean bit registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_q   <= '0;
            clean_q <= RESET_VAL;
        end else begin
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
        end
    end

    assign clean_o = clean_q;

endmodule

// File: rtl/jamma_joy_scanner.sv
// JAMMA joystick splitter scanner: drives the select line, waits for the
// external mux to settle, then samples and debounces both players and coins.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// SETTLE_A | select = P1, waiting SETTLE_CYCLES for the mux to settle
// SAMPLE_A | P1 image and coins captured into the debouncers
// SETTLE_B | select = P2, waiting SETTLE_CYCLES for the mux to settle
// SAMPLE_B | P2 image and coins captured, scan tick issued next cycle
module jamma_joy_scanner
    import jamma_joy_scanner_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 4,
    parameter int DEBOUNCE_SCANS = 3
) (
    input  logic       clk_i,
    input  logic       reset_n_i,
    input  logic [7:0] jjoy_i,
    input  logic [1:0] jcoin_i,
    input  logic [5:0] local_joy_i,
    output logic       jselect_o,
    output logic [7:0] joy1_o,
    output logic [7:0] joy2_o,
    output logic [1:0] coin_o,
    output logic       scan_tick_o
);

    localparam int            SW          = $clog2(SETTLE_CYCLES + 1);
    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);

    scan_state_e   state_q;
    logic [SW-1:0] settle_q;
    logic          jsel_q;
    logic          tick_q;

    logic [7:0] p1_raw, p2_raw;
    logic       en_a, en_b, en_coin;

    // Scan sequencer; settle timer counts down to zero, select and tick are registered.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q  <= SETTLE_A;
            settle_q <= SETTLE_LOAD;
            jsel_q   <= JSEL_P1;
            tick_q   <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            case (state_q)
                SETTLE_A: begin
                    if (settle_q == '0) state_q <= SAMPLE_A;
                    else                settle_q <= settle_q - SW'(1);
                end
                SAMPLE_A: begin
                    state_q  <= SETTLE_B;
                    settle_q <= SETTLE_LOAD;
                    jsel_q   <= JSEL_P2;
                end
                SETTLE_B: begin
                    if (settle_q == '0) state_q <= SAMPLE_B;
                    else                settle_q <= settle_q - SW'(1);
                end
                SAMPLE_B: begin
                    state_q  <= SETTLE_A;
                    settle_q <= SETTLE_LOAD;
                    jsel_q   <= JSEL_P1;
                    tick_q   <= 1'b1;
                end
                default: begin
                    state_q  <= SETTLE_A;
                    settle_q <= SETTLE_LOAD;
                    jsel_q   <= JSEL_P1;
                end
            endcase
        end
    end

    // The on-board stick is wire-ORed (active low) into player 1 only.
    assign p1_raw  = jjoy_i & {2'b11, local_joy_i};
    assign p2_raw  = jjoy_i;
    assign en_a    = (state_q == SAMPLE_A);
    assign en_b    = (state_q == SAMPLE_B);
    assign en_coin = en_a | en_b;

    for (genvar i = 0; i < 8; i++) begin : g_joy
        jamma_debounce_bit #(.DEBOUNCE_SCANS(DEBOUNCE_SCANS), .RESET_VAL(JOY_IDLE[i])) u_p1 (
            .clk_i       (clk_i),
            .rst_n_i     (reset_n_i),
            .sample_en_i (en_a),
            .raw_i       (p1_raw[i]),
            .clean_o     (joy1_o[i])
        );
        jamma_debounce_bit #(.DEBOUNCE_SCANS(DEBOUNCE_SCANS), .RESET_VAL(JOY_IDLE[i])) u_p2 (
            .clk_i       (clk_i),
            .rst_n_i     (reset_n_i),
            .sample_en_i (en_b),
            .raw_i       (p2_raw[i]),
            .clean_o     (joy2_o[i])
        );
    end

    // Coins are not multiplexed, so they are sampled in both phases.
    for (genvar i = 0; i < 2; i++) begin : g_coin
        jamma_debounce_bit #(.DEBOUNCE_SCANS(DEBOUNCE_SCANS), .RESET_VAL(COIN_IDLE[i])) u_coin (
            .clk_i       (clk_i),
            .rst_n_i     (reset_n_i),
            .sample_en_i (en_coin),
            .raw_i       (jcoin_i[i]),
            .clean_o     (coin_o[i])
        );
    end

    assign jselect_o   = jsel_q;
    assign scan_tick_o = tick_q;

endmodule

// File: tb/tb_jamma_joy_scanner.sv
// Directed bench for jamma_joy_scanner at default parameters (settle 4, debounce 3).
// Cycle numbering: cycle 0 is the first cycle after the posedge that applied reset;
// SAMPLE_A occupies cycles 4,14,24..., SAMPLE_B cycles 9,19,29...
module tb_jamma_joy_scanner;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] jjoy = 8'hFF;
    logic [1:0] jcoin = 2'b11;
    logic [5:0] local_joy = 6'h3F;
    logic       jselect;
    logic [7:0] joy1, joy2;
    logic [1:0] coin;
    logic       scan_tick;

    int         cyc = 0;
    int         tests = 0;
    int         fails = 0;
    logic [7:0] p1_word = 8'hFF;
    logic [7:0] p2_word = 8'hFF;

    jamma_joy_scanner dut (
        .clk_i       (clk),
        .reset_n_i   (reset_n),
        .jjoy_i      (jjoy),
        .jcoin_i     (jcoin),
        .local_joy_i (local_joy),
        .jselect_o   (jselect),
        .joy1_o      (joy1),
        .joy2_o      (joy2),
        .coin_o      (coin),
        .scan_tick_o (scan_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s @cyc %0d: observed %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    // Advance one cycle; the bus carries the word of whichever player the select phase routes.
    task automatic adv1();
        @(negedge clk);
        cyc++;
        jjoy = ((cyc % 10) < 5) ? p1_word : p2_word;
    endtask

    task automatic adv_to(input int target);
        while (cyc < target) adv1();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        cyc  = 0;
        jjoy = p1_word;
    endtask

    initial begin
        // 1: idle scan timing and reset values
        do_reset();
        chk("rst_jsel", 8'(jselect), 8'h00);
        chk("rst_joy1", joy1, 8'hFF);
        chk("rst_joy2", joy2, 8'hFF);
        chk("rst_coin", 8'(coin), 8'h03);
        chk("rst_tick", 8'(scan_tick), 8'h00);
        for (int k = 1; k <= 20; k++) begin
            adv1();
            chk("idle_jsel", 8'(jselect), 8'(((cyc / 5) % 2) == 1));
            chk("idle_tick", 8'(scan_tick), 8'((cyc % 10) == 0));
        end
        chk("idle_joy1", joy1, 8'hFF);
        chk("idle_joy2", joy2, 8'hFF);

        // 2: P1 bit0 held low only in the P1 phase
        p1_word = 8'hFE; p2_word = 8'hFF;
        do_reset();
        adv_to(24); chk("p1b0_before", joy1, 8'hFF);
        adv_to(25); chk("p1b0_after", joy1, 8'hFE);
        chk("p1b0_joy2", joy2, 8'hFF);
        adv_to(30); chk("p1b0_joy2_late", joy2, 8'hFF);
        chk("p1b0_hold", joy1, 8'hFE);

        // 3: two-sample glitch rejected, three-sample press accepted then released
        p1_word = 8'hFB;
        do_reset();
        adv_to(15); p1_word = 8'hFF;
        adv_to(25); chk("glitch2_a", joy1, 8'hFF);
        adv_to(45); chk("glitch2_b", joy1, 8'hFF);
        p1_word = 8'hFB;
        adv_to(74); chk("press3_before", joy1, 8'hFF);
        adv_to(75); chk("press3_after", joy1, 8'hFB);
        p1_word = 8'hFF;
        adv_to(104); chk("release_before", joy1, 8'hFB);
        adv_to(105); chk("release_after", joy1, 8'hFF);

        // 4: local joystick merges into P1 only
        p1_word = 8'hFF; p2_word = 8'hFF; local_joy = 6'b111101;
        do_reset();
        adv_to(24); chk("local_before", joy1, 8'hFF);
        adv_to(25); chk("local_after", joy1, 8'hFD);
        adv_to(30); chk("local_joy2", joy2, 8'hFF);
        local_joy = 6'h3F;

        // 5: coin sampled in both phases
        jcoin = 2'b10;
        do_reset();
        adv_to(10); chk("coin_mid", 8'(coin), 8'h03);
        adv_to(14); chk("coin_before", 8'(coin), 8'h03);
        adv_to(15); chk("coin_after", 8'(coin), 8'h02);
        chk("coin_joy1", joy1, 8'hFF);
        jcoin = 2'b11;

        // 6: reset during SETTLE_B with a partial P2 run pending
        p2_word = 8'h7F;
        do_reset();
        adv_to(29); chk("p2_before", joy2, 8'hFF);
        adv_to(30); chk("p2_after", joy2, 8'h7F);
        p2_word = 8'hFF;
        adv_to(55); chk("p2_partial_hold", joy2, 8'h7F);
        chk("p2_settle_b_jsel", 8'(jselect), 8'h01);
        do_reset();
        chk("mid_rst_jsel", 8'(jselect), 8'h00);
        chk("mid_rst_joy2", joy2, 8'hFF);
        chk("mid_rst_tick", 8'(scan_tick), 8'h00);
        p2_word = 8'h7F;
        adv_to(29); chk("redeb_before", joy2, 8'hFF);
        adv_to(30); chk("redeb_after", joy2, 8'h7F);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
